// File: rtl/conv11_compute.sv
// Per-output-channel MAC engine for the 1x1 convolution layer: multiplies CIN
// (activation, weight) beats, adds a bias, then rounds, shifts, ReLUs and saturates.
module conv11_compute #(
  parameter int IN_WIDTH  = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int CIN       = 16,
  parameter int SHIFT     = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic signed [W_WIDTH-1:0]   in_weight,
  input  logic signed [ACC_WIDTH-1:0] bias,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        busy
);

  localparam int CW = (CIN > 1) ? $clog2(CIN) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(CIN - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND_C =
    (SHIFT > 0) ? (ACC_WIDTH'(1'b1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : {ACC_WIDTH{1'b0}};
  localparam logic signed [ACC_WIDTH-1:0] OMAX_C =
    {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  // Round-half-up, arithmetic shift, then clamp into the unsigned output range.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] sum);
    logic signed [ACC_WIDTH-1:0] r;
    r = (sum + RND_C) >>> SHIFT;
    if (r[ACC_WIDTH-1]) begin
      requant = {OUT_WIDTH{1'b0}};
    end else if (r > OMAX_C) begin
      requant = {OUT_WIDTH{1'b1}};
    end else begin
      requant = r[OUT_WIDTH-1:0];
    end
  endfunction

  logic [CW-1:0]                count_r, count_nxt_s;
  logic                         s1_valid_r, s1_first_r, s1_last_r;
  logic                         s1_valid_nxt_s, s1_first_nxt_s, s1_last_nxt_s;
  logic signed [ACC_WIDTH-1:0]  s1_prod_r, s1_prod_nxt_s;
  logic signed [ACC_WIDTH-1:0]  bias_r, bias_nxt_s;
  logic signed [ACC_WIDTH-1:0]  acc_r, acc_nxt_s;
  logic                         s2_valid_r, s2_valid_nxt_s;
  logic signed [ACC_WIDTH-1:0]  s2_sum_r, s2_sum_nxt_s;
  logic                         out_valid_r, out_valid_nxt_s;
  logic [OUT_WIDTH-1:0]         out_data_r, out_data_nxt_s;
  logic                         busy_r, busy_nxt_s;

  logic                              beat_s;
  logic signed [IN_WIDTH+W_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]       acc_sum_s;

  assign prod_s = in_data * in_weight;

  // Next-state for the counter and the three pipeline stages; flush overrides everything.
  always_comb begin
    beat_s         = in_valid & ~flush;
    count_nxt_s    = count_r;
    s1_valid_nxt_s = beat_s;
    s1_first_nxt_s = s1_first_r;
    s1_last_nxt_s  = s1_last_r;
    s1_prod_nxt_s  = s1_prod_r;
    bias_nxt_s     = bias_r;
    acc_nxt_s      = acc_r;
    s2_valid_nxt_s = 1'b0;
    s2_sum_nxt_s   = s2_sum_r;
    out_valid_nxt_s = 1'b0;
    out_data_nxt_s = out_data_r;

    // A first-tagged product starts a fresh sum regardless of what acc holds.
    if (s1_first_r) begin
      acc_sum_s = s1_prod_r;
    end else begin
      acc_sum_s = acc_r + s1_prod_r;
    end

    if (flush) begin
      count_nxt_s = {CW{1'b0}};
      acc_nxt_s   = {ACC_WIDTH{1'b0}};
    end else begin
      if (beat_s) begin
        s1_first_nxt_s = (count_r == {CW{1'b0}});
        s1_last_nxt_s  = (count_r == LAST_C);
        s1_prod_nxt_s  = ACC_WIDTH'(prod_s);
        if (count_r == {CW{1'b0}}) begin
          bias_nxt_s = bias;
        end else begin
          bias_nxt_s = bias_r;
        end
        if (count_r == LAST_C) begin
          count_nxt_s = {CW{1'b0}};
        end else begin
          count_nxt_s = count_r + CW'(1'b1);
        end
      end else begin
        count_nxt_s = count_r;
      end

      if (s1_valid_r) begin
        acc_nxt_s = acc_sum_s;
        if (s1_last_r) begin
          s2_valid_nxt_s = 1'b1;
          s2_sum_nxt_s   = acc_sum_s + bias_r;
        end else begin
          s2_valid_nxt_s = 1'b0;
        end
      end else begin
        acc_nxt_s = acc_r;
      end

      if (s2_valid_r) begin
        out_valid_nxt_s = 1'b1;
        out_data_nxt_s  = requant(s2_sum_r);
      end else begin
        out_valid_nxt_s = 1'b0;
      end
    end

    busy_nxt_s = (count_nxt_s != {CW{1'b0}}) | s1_valid_nxt_s | s2_valid_nxt_s | out_valid_nxt_s;
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= {CW{1'b0}};
      s1_valid_r  <= 1'b0;
      s1_first_r  <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_prod_r   <= {ACC_WIDTH{1'b0}};
      bias_r      <= {ACC_WIDTH{1'b0}};
      acc_r       <= {ACC_WIDTH{1'b0}};
      s2_valid_r  <= 1'b0;
      s2_sum_r    <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      s1_valid_r  <= s1_valid_nxt_s;
      s1_first_r  <= s1_first_nxt_s;
      s1_last_r   <= s1_last_nxt_s;
      s1_prod_r   <= s1_prod_nxt_s;
      bias_r      <= bias_nxt_s;
      acc_r       <= acc_nxt_s;
      s2_valid_r  <= s2_valid_nxt_s;
      s2_sum_r    <= s2_sum_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_conv11_compute.sv
// Scoreboard bench for conv11_compute: stimulus pushes expected results with their
// due cycle, an independent monitor pops and compares on every out_valid pulse.
module tb_conv11_compute;
  localparam int IW = 8, WW = 8, AW = 24, OW = 8, CIN = 4, SH = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic signed [IW-1:0] in_data = '0;
  logic signed [WW-1:0] in_weight = '0;
  logic signed [AW-1:0] bias = '0;
  logic out_valid, busy;
  logic [OW-1:0] out_data;

  conv11_compute #(.IN_WIDTH(IW), .W_WIDTH(WW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
                   .CIN(CIN), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_weight(in_weight), .bias(bias), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int at; } exp_t;
  exp_t q[$];
  exp_t e;
  int pcyc[$];
  int pval[$];
  int total = 0, bad = 0;
  int m_cnt = 0;
  longint m_sum = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference requantization: floor division after adding half, then clamp.
  function automatic int ref_q(input longint s);
    longint dv, x, r;
    dv = longint'(1) << SH;
    x = s + ((SH > 0) ? dv / 2 : 0);
    if (x >= 0) r = x / dv;
    else r = -((-x + dv - 1) / dv);
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return int'(r);
  endfunction

  // Monitor: flags overdue expectations, then checks any pulse against the queue head.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at < cyc) begin
      total++; bad++;
      $display("FAIL missing_pulse: got no pulse, required value %0d at cycle %0d", q[0].val, q[0].at);
      void'(q.pop_front());
    end
    if (rst && out_valid) begin
      pcyc.push_back(cyc);
      pval.push_back(int'(out_data));
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got data %0d at cycle %0d, required none", out_data, cyc);
      end else begin
        e = q.pop_front();
        check("out_cycle", cyc, e.at);
        check("out_data", out_data, e.val);
      end
    end
  end

  task automatic step(input logic v, input int d, input int w, input int b, input logic f);
    @(posedge clk); #1;
    in_valid = v; in_data = IW'(d); in_weight = WW'(w); bias = AW'(b); flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic beat(input int d, input int w, input int b);
    step(1'b1, d, w, b, 1'b0);
    if (m_cnt == 0) m_sum = b;
    m_sum += longint'(d) * longint'(w);
    m_cnt++;
    if (m_cnt == CIN) begin
      q.push_back('{ref_q(m_sum), cyc + 3});
      m_cnt = 0;
    end
  endtask

  task automatic group(input int d, input int w, input int b, input int gap_max);
    for (int i = 0; i < CIN; i++) begin
      beat(d, w, b);
      if (gap_max > 0 && i < CIN - 1) idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic do_flush(input logic with_beat, input int d, input int w);
    step(with_beat, d, w, 0, 1'b1);
    m_cnt = 0;
    while (q.size() > 0 && q[q.size()-1].at > cyc) void'(q.pop_back());
  endtask

  task automatic do_reset(input string name, input logic ov_before, input logic busy_before);
    step(1'b0, 0, 0, 0, 1'b0);
    check({name, "_ov_before"}, out_valid, ov_before);
    check({name, "_busy_before"}, busy, busy_before);
    #1 rst = 1'b0;
    q.delete();
    m_cnt = 0;
    #1;
    check({name, "_ov_rst"}, out_valid, 0);
    check({name, "_data_rst"}, out_data, 0);
    check({name, "_busy_rst"}, busy, 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
  endtask

  task automatic expect_last(input string name, input int pulses_before, input int npulse, input int val);
    check({name, "_pulses"}, pcyc.size() - pulses_before, npulse);
    if (npulse > 0) check({name, "_value"}, pval[pval.size()-1], val);
  endtask

  int p0;
  int rd, rw, rb;

  initial begin
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    #1 rst = 1'b1;

    // Basic product sum and busy behaviour.
    p0 = pcyc.size();
    beat(64, 64, 0); beat(64, 64, 0);
    check("busy_mid_group", busy, 1);
    beat(64, 64, 0); beat(64, 64, 0);
    idle(4);
    check("busy_after_pulse", busy, 0);
    expect_last("basic", p0, 1, 128);

    p0 = pcyc.size(); group(64, -64, 0, 0); idle(4); expect_last("relu", p0, 1, 0);
    p0 = pcyc.size(); group(127, 127, 0, 0); idle(4); expect_last("saturate", p0, 1, 255);
    p0 = pcyc.size(); group(48, 1, 0, 0); idle(4); expect_last("round_192", p0, 1, 2);
    p0 = pcyc.size(); group(0, 0, 64, 0); idle(4); expect_last("bias_64", p0, 1, 1);
    p0 = pcyc.size(); group(0, 0, 63, 0); idle(4); expect_last("bias_63", p0, 1, 0);

    // Back-to-back groups at full rate.
    p0 = pcyc.size();
    group(0, 0, 0, 0); group(0, 0, 128, 0); group(0, 0, 256, 0);
    idle(4);
    check("b2b_pulses", pcyc.size() - p0, 3);
    if (pcyc.size() - p0 == 3) begin
      check("b2b_gap1", pcyc[p0+1] - pcyc[p0], 4);
      check("b2b_gap2", pcyc[p0+2] - pcyc[p0+1], 4);
      check("b2b_v0", pval[p0], 0);
      check("b2b_v1", pval[p0+1], 1);
      check("b2b_v2", pval[p0+2], 2);
    end

    // Same groups with random stalls inside each group.
    p0 = pcyc.size();
    group(0, 0, 0, 3); group(0, 0, 128, 3); group(0, 0, 256, 3);
    idle(4);
    check("gap_pulses", pcyc.size() - p0, 3);

    // Flush mid-group, flush on the last beat, flush while a sum is in the pipe.
    p0 = pcyc.size();
    beat(64, 64, 0); beat(64, 64, 0); do_flush(1'b0, 0, 0);
    group(64, 64, 0, 0); idle(4);
    expect_last("flush_mid", p0, 1, 128);
    p0 = pcyc.size();
    beat(10, 10, 0); beat(10, 10, 0); beat(10, 10, 0); do_flush(1'b1, 10, 10);
    idle(5);
    expect_last("flush_last", p0, 0, 0);
    p0 = pcyc.size();
    group(64, 64, 0, 0); idle(1); do_flush(1'b0, 0, 0); idle(4);
    expect_last("flush_pipe", p0, 0, 0);

    // Asynchronous reset mid-group and while the result is on the output.
    beat(64, 64, 0); beat(64, 64, 0);
    do_reset("rst_mid", 1'b0, 1'b1);
    p0 = pcyc.size(); group(64, 64, 0, 0); idle(4); expect_last("after_rst_mid", p0, 1, 128);
    group(127, 127, 0, 0); idle(2);
    do_reset("rst_s3", 1'b1, 1'b1);
    p0 = pcyc.size(); group(64, 64, 0, 0); idle(4); expect_last("after_rst_s3", p0, 1, 128);

    // Random beats, gaps and occasional flushes against the model.
    for (int i = 0; i < 200; i++) begin
      rd = int'($urandom_range(0, 255)) - 128;
      rw = int'($urandom_range(0, 255)) - 128;
      rb = int'($urandom_range(0, 131072)) - 65536;
      if ($urandom_range(0, 19) == 0) do_flush(1'(($urandom_range(0, 1))), rd, rw);
      else beat(rd, rw, rb);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(6);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
